// File: rtl/ffe_pkg.sv
// Shared definitions for the FFE coefficient loader and controller:
// FSM state encodings and default tap geometry.
package ffe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_PENDING = 2'd2
   } ffe_state_t;

   localparam int DEFAULT_DEPTH       = 4;
   localparam int DEFAULT_COEFF_WIDTH = 8;

endpackage

// File: rtl/ffe_coeff_bank.sv
// One DEPTH-entry coefficient register bank: single write port,
// combinational read port, asynchronous clear to zero.
module ffe_coeff_bank #(
   parameter int DEPTH       = 4,
   parameter int COEFF_WIDTH = 8,
   parameter int ADDR_SIZE   = $clog2(DEPTH)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_we,
   input  logic [ADDR_SIZE-1:0]   i_waddr,
   input  logic [COEFF_WIDTH-1:0] i_wdata,
   input  logic [ADDR_SIZE-1:0]   i_raddr,
   output logic [COEFF_WIDTH-1:0] o_rdata
);

   logic [COEFF_WIDTH-1:0] r_mem [DEPTH];

   // Storage: cleared on reset, written one entry per accepted beat.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ffe_coeff_loader.sv
// Coefficient loader: streams DEPTH taps into the shadow bank, then swaps
// shadow and active banks only when the controller signals a pass boundary.
//
// Handshake: a beat transfers on a rising edge where coeff_valid and
// coeff_ready are both high. coeff_ready depends only on the FSM state (high
// in FILL), never on coeff_valid; the source may hold or drop coeff_valid
// freely, and a beat offered while coeff_ready is low is simply not taken.
module ffe_coeff_loader
   import ffe_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
   parameter int ADDR_SIZE   = $clog2(DEPTH)
) (
   input  logic                   ffe_clk,
   input  logic                   rst,
   input  logic                   cfg_start,
   input  logic [COEFF_WIDTH-1:0] coeff_in,
   input  logic                   coeff_valid,
   output logic                   coeff_ready,
   input  logic                   swap_ok,
   input  logic [ADDR_SIZE-1:0]   rd_addr,
   output logic [COEFF_WIDTH-1:0] coeff_out,
   output logic                   active_bank,
   output logic                   load_done,
   output logic                   load_busy,
   output ffe_state_t             dbg_state
);

   localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);

   ffe_state_t             r_state;
   ffe_state_t             w_state_nxt;
   logic [ADDR_SIZE-1:0]   r_wr_ptr;
   logic [ADDR_SIZE-1:0]   w_ptr_nxt;
   logic [ADDR_SIZE-1:0]   w_wr_addr;
   logic                   r_active_bank;
   logic                   r_load_done;
   logic                   w_wr_fire;
   logic                   w_swap;
   logic                   w_coeff_ready;
   logic                   w_load_busy;
   logic                   w_we0;
   logic                   w_we1;
   logic [COEFF_WIDTH-1:0] w_rdata0;
   logic [COEFF_WIDTH-1:0] w_rdata1;

   // State register.
   always_ff @(posedge ffe_clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, write pointer update, handshake and swap decisions.
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_wr_ptr;
      w_wr_addr     = r_wr_ptr;
      w_wr_fire     = 1'b0;
      w_swap        = 1'b0;
      w_coeff_ready = 1'b0;
      w_load_busy   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cfg_start) begin
               w_state_nxt = ST_FILL;
               w_ptr_nxt   = '0;
            end
         end
         ST_FILL: begin
            w_coeff_ready = 1'b1;
            w_load_busy   = 1'b1;
            w_wr_fire     = coeff_valid;
            if (cfg_start) begin
               // Restart: a beat taken this same cycle lands at tap 0.
               w_wr_addr = '0;
               w_ptr_nxt = coeff_valid ? ADDR_SIZE'(1) : '0;
            end else if (coeff_valid) begin
               w_ptr_nxt = r_wr_ptr + ADDR_SIZE'(1);
               if (r_wr_ptr == LAST_IDX) begin
                  w_state_nxt = ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            w_load_busy = 1'b1;
            if (swap_ok) begin
               w_swap      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Write pointer, bank select and the registered done pulse.
   always_ff @(posedge ffe_clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr      <= '0;
         r_active_bank <= 1'b0;
         r_load_done   <= 1'b0;
      end else begin
         r_wr_ptr      <= w_ptr_nxt;
         r_active_bank <= r_active_bank ^ w_swap;
         r_load_done   <= w_swap;
      end
   end

   // Only the shadow bank (the one not selected) is ever written.
   assign w_we0 = w_wr_fire &  r_active_bank;
   assign w_we1 = w_wr_fire & ~r_active_bank;

   ffe_coeff_bank #(
      .DEPTH       (DEPTH),
      .COEFF_WIDTH (COEFF_WIDTH),
      .ADDR_SIZE   (ADDR_SIZE)
   ) u_bank0 (
      .i_clk   (ffe_clk),
      .i_rst_n (rst),
      .i_we    (w_we0),
      .i_waddr (w_wr_addr),
      .i_wdata (coeff_in),
      .i_raddr (rd_addr),
      .o_rdata (w_rdata0)
   );

   ffe_coeff_bank #(
      .DEPTH       (DEPTH),
      .COEFF_WIDTH (COEFF_WIDTH),
      .ADDR_SIZE   (ADDR_SIZE)
   ) u_bank1 (
      .i_clk   (ffe_clk),
      .i_rst_n (rst),
      .i_we    (w_we1),
      .i_waddr (w_wr_addr),
      .i_wdata (coeff_in),
      .i_raddr (rd_addr),
      .o_rdata (w_rdata1)
   );

   assign coeff_out   = r_active_bank ? w_rdata1 : w_rdata0;
   assign active_bank = r_active_bank;
   assign load_done   = r_load_done;
   assign coeff_ready = w_coeff_ready;
   assign load_busy   = w_load_busy;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_ffe_coeff_loader.sv
// Directed bench for ffe_coeff_loader: one task per scenario, inline checks.
module tb_ffe_coeff_loader;
   import ffe_pkg::*;

   logic       ffe_clk;
   logic       rst;
   logic       cfg_start;
   logic [7:0] coeff_in;
   logic       coeff_valid;
   logic       coeff_ready;
   logic       swap_ok;
   logic [1:0] rd_addr;
   logic [7:0] coeff_out;
   logic       active_bank;
   logic       load_done;
   logic       load_busy;
   ffe_state_t dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   ffe_coeff_loader #(.DEPTH(4), .COEFF_WIDTH(8)) dut (
      .ffe_clk     (ffe_clk),
      .rst         (rst),
      .cfg_start   (cfg_start),
      .coeff_in    (coeff_in),
      .coeff_valid (coeff_valid),
      .coeff_ready (coeff_ready),
      .swap_ok     (swap_ok),
      .rd_addr     (rd_addr),
      .coeff_out   (coeff_out),
      .active_bank (active_bank),
      .load_done   (load_done),
      .load_busy   (load_busy),
      .dbg_state   (dbg_state)
   );

   // Clock: rising edges at 5, 15, 25 ...
   initial begin
      ffe_clk = 1'b0;
      forever #5 ffe_clk = ~ffe_clk;
   end

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge ffe_clk);
      #1;
   endtask

   // Driver: one-cycle cfg_start strobe with no beat.
   task automatic start_cfg();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   // Driver: present one beat for one cycle.
   task automatic send_beat(input logic [7:0] d);
      coeff_valid = 1'b1;
      coeff_in    = d;
      tick();
      coeff_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] exp_set [4];
      exp_set = '{8'h00, 8'h00, 8'h00, 8'h00};
      rst = 1'b0;
      #3;
      n_tests++; if (coeff_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", coeff_ready); end
      n_tests++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", load_busy); end
      n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", load_done); end
      n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL reset_bank got %b want 0", active_bank); end
      n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== exp_set[a]) begin n_fail++; $display("FAIL reset_coeff[%0d] got %h want %h", a, coeff_out, exp_set[a]); end
      end
      @(negedge ffe_clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_load();
      logic [7:0] exp_set [4];
      exp_set = '{8'h01, 8'h02, 8'h03, 8'hFF};
      swap_ok = 1'b1;
      start_cfg();
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (coeff_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready[%0d] got %b want 1", i, coeff_ready); end
         send_beat(exp_set[i]);
      end
      n_tests++; if (dbg_state !== ST_PENDING) begin n_fail++; $display("FAIL load_pending got %0d want 2", dbg_state); end
      n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL load_done_early got %b want 0", load_done); end
      n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL load_bank_early got %b want 0", active_bank); end
      tick();
      n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL load_done got %b want 1", load_done); end
      n_tests++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL load_bank got %b want 1", active_bank); end
      n_tests++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_after got %b want 0", load_busy); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== exp_set[a]) begin n_fail++; $display("FAIL load_coeff[%0d] got %h want %h", a, coeff_out, exp_set[a]); end
      end
      tick();
      n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL load_done_width got %b want 0", load_done); end
   endtask

   task automatic test_deferred_swap();
      logic [7:0] old_set [4];
      logic [7:0] exp_set [4];
      old_set = '{8'h01, 8'h02, 8'h03, 8'hFF};
      exp_set = '{8'h21, 8'h22, 8'h23, 8'h24};
      swap_ok = 1'b0;
      start_cfg();
      for (int i = 0; i < 4; i++) send_beat(exp_set[i]);
      for (int c = 0; c < 10; c++) begin
         rd_addr = c[1:0];
         #1;
         n_tests++; if (coeff_out !== old_set[c % 4]) begin n_fail++; $display("FAIL defer_coeff[%0d] got %h want %h", c, coeff_out, old_set[c % 4]); end
         n_tests++; if (coeff_ready !== 1'b0) begin n_fail++; $display("FAIL defer_ready[%0d] got %b want 0", c, coeff_ready); end
         n_tests++; if (load_busy !== 1'b1) begin n_fail++; $display("FAIL defer_busy[%0d] got %b want 1", c, load_busy); end
         n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL defer_done[%0d] got %b want 0", c, load_done); end
         tick();
      end
      swap_ok = 1'b1;
      tick();
      swap_ok = 1'b0;
      n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL defer_done got %b want 1", load_done); end
      n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL defer_bank got %b want 0", active_bank); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== exp_set[a]) begin n_fail++; $display("FAIL defer_new[%0d] got %h want %h", a, coeff_out, exp_set[a]); end
      end
      tick();
   endtask

   task automatic test_gapped_valid();
      logic [7:0] exp_set [4];
      exp_set = '{8'h31, 8'h32, 8'h33, 8'h34};
      swap_ok = 1'b0;
      start_cfg();
      for (int i = 0; i < 4; i++) begin
         send_beat(exp_set[i]);
         if (i < 3) begin
            coeff_in = 8'hEE;
            tick();
            n_tests++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL gap_state[%0d] got %0d want 1", i, dbg_state); end
         end
      end
      n_tests++; if (dbg_state !== ST_PENDING) begin n_fail++; $display("FAIL gap_pending got %0d want 2", dbg_state); end
      swap_ok = 1'b1;
      tick();
      swap_ok = 1'b0;
      n_tests++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL gap_bank got %b want 1", active_bank); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== exp_set[a]) begin n_fail++; $display("FAIL gap_coeff[%0d] got %h want %h", a, coeff_out, exp_set[a]); end
      end
      tick();
   endtask

   task automatic test_restart();
      logic [7:0] exp_set [4];
      exp_set = '{8'h10, 8'h11, 8'h12, 8'h13};
      swap_ok = 1'b0;
      start_cfg();
      send_beat(8'hAA);
      send_beat(8'hBB);
      // Restart strobe together with the first beat of the new set.
      cfg_start   = 1'b1;
      coeff_valid = 1'b1;
      coeff_in    = exp_set[0];
      tick();
      cfg_start   = 1'b0;
      coeff_valid = 1'b0;
      n_tests++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL restart_state got %0d want 1", dbg_state); end
      for (int i = 1; i < 4; i++) send_beat(exp_set[i]);
      n_tests++; if (dbg_state !== ST_PENDING) begin n_fail++; $display("FAIL restart_pending got %0d want 2", dbg_state); end
      swap_ok = 1'b1;
      tick();
      swap_ok = 1'b0;
      n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL restart_done got %b want 1", load_done); end
      n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL restart_bank got %b want 0", active_bank); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== exp_set[a]) begin n_fail++; $display("FAIL restart_coeff[%0d] got %h want %h", a, coeff_out, exp_set[a]); end
      end
      tick();
   endtask

   task automatic test_cfg_in_pending();
      logic [7:0] exp_set [4];
      exp_set = '{8'h41, 8'h42, 8'h43, 8'h44};
      swap_ok = 1'b0;
      start_cfg();
      for (int i = 0; i < 4; i++) send_beat(exp_set[i]);
      start_cfg();
      n_tests++; if (dbg_state !== ST_PENDING) begin n_fail++; $display("FAIL pend_state got %0d want 2", dbg_state); end
      n_tests++; if (coeff_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready got %b want 0", coeff_ready); end
      swap_ok = 1'b1;
      tick();
      swap_ok = 1'b0;
      n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL pend_done got %b want 1", load_done); end
      n_tests++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL pend_bank got %b want 1", active_bank); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== exp_set[a]) begin n_fail++; $display("FAIL pend_coeff[%0d] got %h want %h", a, coeff_out, exp_set[a]); end
      end
      tick();
      n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL pend_single_pulse got %b want 0", load_done); end
      n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL pend_idle got %0d want 0", dbg_state); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] set_a [4];
      logic [7:0] set_b [4];
      set_a = '{8'h61, 8'h62, 8'h63, 8'h64};
      set_b = '{8'h71, 8'h72, 8'h73, 8'h74};
      swap_ok = 1'b1;
      // cfg_start in IDLE with a beat offered: the beat must not be taken.
      cfg_start   = 1'b1;
      coeff_valid = 1'b1;
      coeff_in    = 8'h55;
      #1;
      n_tests++; if (coeff_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ready got %b want 0", coeff_ready); end
      tick();
      cfg_start   = 1'b0;
      coeff_valid = 1'b0;
      for (int i = 0; i < 4; i++) send_beat(set_a[i]);
      tick();
      n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_a got %b want 1", load_done); end
      n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL b2b_bank_a got %b want 0", active_bank); end
      cfg_start = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== set_a[a]) begin n_fail++; $display("FAIL b2b_coeff_a[%0d] got %h want %h", a, coeff_out, set_a[a]); end
      end
      tick();
      cfg_start = 1'b0;
      n_tests++; if (dbg_state !== ST_FILL) begin n_fail++; $display("FAIL b2b_refill got %0d want 1", dbg_state); end
      n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_low got %b want 0", load_done); end
      for (int i = 0; i < 4; i++) send_beat(set_b[i]);
      tick();
      n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_b got %b want 1", load_done); end
      n_tests++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL b2b_bank_b got %b want 1", active_bank); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== set_b[a]) begin n_fail++; $display("FAIL b2b_coeff_b[%0d] got %h want %h", a, coeff_out, set_b[a]); end
      end
      swap_ok = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_fill();
      swap_ok = 1'b0;
      start_cfg();
      send_beat(8'h81);
      send_beat(8'h82);
      send_beat(8'h83);
      rst = 1'b0;
      #1;
      n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rmid_state got %0d want 0", dbg_state); end
      n_tests++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL rmid_bank got %b want 0", active_bank); end
      n_tests++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", load_busy); end
      for (int a = 0; a < 4; a++) begin
         rd_addr = a[1:0];
         #1;
         n_tests++; if (coeff_out !== 8'h00) begin n_fail++; $display("FAIL rmid_coeff[%0d] got %h want 00", a, coeff_out); end
      end
      @(negedge ffe_clk);
      rst = 1'b1;
      swap_ok = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rmid_done[%0d] got %b want 0", c, load_done); end
         n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rmid_idle[%0d] got %0d want 0", c, dbg_state); end
      end
      swap_ok = 1'b0;
   endtask

   initial begin
      rst         = 1'b0;
      cfg_start   = 1'b0;
      coeff_in    = 8'h00;
      coeff_valid = 1'b0;
      swap_ok     = 1'b0;
      rd_addr     = 2'd0;
      test_reset();
      test_load();
      test_deferred_swap();
      test_gapped_valid();
      test_restart();
      test_cfg_in_pending();
      test_back_to_back();
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ffe_coeff_loader.md
# ffe_coeff_loader

Coefficient writer for the FFE datapath. Accepts a new set of DEPTH tap coefficients over a valid/ready stream and writes them into a shadow bank. It then swaps shadow and active banks only at a safe computation boundary, so the FFE controller's read address always indexes a stable coefficient set. It sits between the configuration interface and the FFE MAC, and is the write-side counterpart of the controller's rd_addr read sequence.

## Interface
- DEPTH, 4, number of taps (power of two, ≥2)
- COEFF_WIDTH, 8, coefficient width, signed two's complement
- ADDR_SIZE, $clog2(DEPTH), tap address width

- ffe_clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cfg_start  input  1  begin loading a new coefficient set (single-cycle strobe)
- coeff_in  input  COEFF_WIDTH  coefficient beat, tap index 0 first
- coeff_valid  input  1  coeff_in valid
- coeff_ready  output  1  loader accepts a beat this cycle
- swap_ok  input  1  controller at pass boundary (driven from controller shift_en, or tied high while controller idle)
- rd_addr  input  ADDR_SIZE  tap index from FFE controller
- coeff_out  output  COEFF_WIDTH  active_bank[rd_addr], combinational read
- active_bank  output  1  bank currently feeding coeff_out
- load_done  output  1  one-cycle pulse: new set now active
- load_busy  output  1  high in FILL or PENDING

## Operation
- Two register banks (0/1), each DEPTH × COEFF_WIDTH. Shadow bank = ~active_bank.
- FSM states: IDLE, FILL, PENDING.
- IDLE: coeff_ready=0, load_busy=0. cfg_start → FILL, wr_ptr←0.
- FILL: coeff_ready=1. On coeff_valid&coeff_ready: shadow[wr_ptr]←coeff_in, wr_ptr←wr_ptr+1. Beat written at wr_ptr=DEPTH-1 → PENDING, wr_ptr wraps to 0.
- PENDING: coeff_ready=0. swap_ok=1 → active_bank toggles, → IDLE.
- cfg_start in FILL: restart. wr_ptr←0, and any beat accepted in the same cycle is written to index 0. Previously written shadow entries are overwritten by the new beats.
- cfg_start in PENDING: ignored. The complete set swaps as normal.
- cfg_start in IDLE together with coeff_valid: no beat is accepted that cycle (coeff_ready=0).
- Active bank is never written. coeff_out is never modified mid-pass.
- Coefficients are stored unmodified (no saturation or sign handling).
- Reset (async, any state): FSM→IDLE, wr_ptr=0, both banks cleared to 0, active_bank=0, load_done=0, load_busy=0, coeff_ready=0. coeff_out then reads 0 for every rd_addr.
- Reset mid-FILL or mid-PENDING discards the partial or pending set.

## Timing
- Write visible in shadow bank at the edge that accepts the beat.
- Minimum load: DEPTH accepted beats, i.e. DEPTH cycles from entering FILL with coeff_valid held high.
- Swap: on the edge where PENDING and swap_ok=1, active_bank toggles. coeff_out reflects the new set in the following cycle; no extra register stage.
- load_done is registered and high for exactly the one cycle following the swap edge, coincident with the new active_bank value.
- PENDING holds indefinitely until swap_ok arrives.
- Back-to-back loads: cfg_start is accepted in the cycle load_done is high (FSM already in IDLE).

## Structure
- Shared package ffe_pkg: FSM state encodings (IDLE=2'd0, FILL=2'd1, PENDING=2'd2) and default DEPTH/COEFF_WIDTH constants, shared with the controller.
- Sub-module ffe_coeff_bank: one DEPTH-entry register bank with write port (we, waddr, wdata), combinational read, and async clear. Instantiated twice. The top level holds the FSM, wr_ptr, bank select and output muxing.

## Test plan
- Reset then load: cfg_start, beats 8'h01,8'h02,8'h03,8'hFF back-to-back, swap_ok=1 → load_done one cycle after 4th-beat PENDING edge; rd_addr 0..3 reads 1,2,3,-1; active_bank=1.
- Deferred swap: load 4 beats with swap_ok=0 for 10 cycles → coeff_out still reads old set, coeff_ready=0, load_busy=1. swap_ok pulse → swap and load_done.
- Gapped valid: beats with coeff_valid toggling 1,0,1,0… → exactly 4 writes at indices 0..3, no skipped or duplicated index.
- Restart: 2 beats (8'hAA,8'hBB), cfg_start, then 4 beats 8'h10..8'h13 → active set reads 10,11,12,13 after swap.
- Reset mid-FILL after 3 beats → coeff_out=0 for all rd_addr, active_bank=0, FSM IDLE, no load_done.
- cfg_start during PENDING → ignored; original set swaps on swap_ok, single load_done pulse.
